// File: rtl/im_ctrl_pkg.sv
// rtl/im_ctrl_pkg.sv - shared types and constants for the IM fetch controller
package im_ctrl_pkg;

    localparam int IM_ADDR_W = 10;
    localparam int IM_DATA_W = 32;
    localparam int IM_DEPTH  = 256;

    localparam logic [IM_DATA_W-1:0] IM_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/im_fetch_if.sv
// rtl/im_fetch_if.sv - boot stream, IM port and decode handshake of the fetch controller
interface im_fetch_if;
    import im_ctrl_pkg::*;

    logic                 LoadValid;
    logic [IM_DATA_W-1:0] LoadData;
    logic                 LoadLast;
    logic                 LoadReady;
    logic                 Start;
    logic [IM_ADDR_W-1:0] ImAddress;
    logic                 ImWe;
    logic [IM_DATA_W-1:0] ImWriteData;
    logic [IM_DATA_W-1:0] ImInstruction;
    logic                 InstrValid;
    logic [IM_DATA_W-1:0] InstrOut;
    logic [IM_ADDR_W-1:0] InstrPc;
    logic                 InstrReady;
    logic                 BranchTaken;
    logic [IM_ADDR_W-1:0] BranchTarget;
    logic                 Halted;

    modport master (
        input  LoadValid, LoadData, LoadLast, Start, ImInstruction,
               InstrReady, BranchTaken, BranchTarget,
        output LoadReady, ImAddress, ImWe, ImWriteData, InstrValid,
               InstrOut, InstrPc, Halted
    );

    modport slave (
        output LoadValid, LoadData, LoadLast, Start, ImInstruction,
               InstrReady, BranchTaken, BranchTarget,
        input  LoadReady, ImAddress, ImWe, ImWriteData, InstrValid,
               InstrOut, InstrPc, Halted
    );

endinterface

// File: rtl/im_fetch_slice.sv
// rtl/im_fetch_slice.sv - one-entry valid/ready output register with flush
module im_fetch_slice #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    output logic              in_ready_o,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_pc_o    = pc_q;

    // Flush drops the held entry whether or not it was accepted this cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
                pc_q   <= in_pc_i;
            end
        end
    end

endmodule

// File: rtl/im_fetch_ctrl.sv
// rtl/im_fetch_ctrl.sv - IM boot loader and instruction fetch sequencer
module im_fetch_ctrl
    import im_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = IM_ADDR_W,
    parameter int                DATA_W    = IM_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = IM_HALT_WORD
) (
    input logic        Clk,
    input logic        Reset,
    im_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'((IM_DEPTH - 1) * 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_e            st_q, st_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              is_halt;
    logic              slot_ready;
    logic              fetch_valid;
    logic              flush;

    assign is_halt = (bus.ImInstruction == HALT_WORD);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            st_q  <= ST_LOAD;
            pc_q  <= RESET_PC;
            ptr_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        ptr_d = ptr_q;
        case (st_q)
            ST_LOAD: begin
                if (bus.LoadValid) begin
                    // The last IM slot ends the load so the pointer never wraps.
                    if (bus.LoadLast || ptr_q == LAST_PTR) begin
                        st_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + WORD_STEP;
                    end
                end
            end
            ST_IDLE, ST_HALTED: begin
                if (bus.Start) begin
                    pc_d = RESET_PC;
                    st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.BranchTaken) begin
                    pc_d = bus.BranchTarget & ~ADDR_W'(3);
                end else if (slot_ready) begin
                    if (is_halt) begin
                        st_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + WORD_STEP;
                    end
                end
            end
            default: st_d = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.LoadReady   = (st_q == ST_LOAD);
        bus.ImWe        = (st_q == ST_LOAD) && bus.LoadValid && !Reset;
        bus.ImAddress   = (st_q == ST_LOAD) ? ptr_q : pc_q;
        bus.ImWriteData = bus.LoadData;
        bus.Halted      = (st_q == ST_HALTED);
        fetch_valid     = (st_q == ST_RUN) && !bus.BranchTaken && !is_halt;
        flush           = ((st_q == ST_RUN) && bus.BranchTaken)
                       || ((st_q == ST_HALTED) && bus.Start);
    end

    im_fetch_slice #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_slice (
        .Clk        (Clk),
        .Reset      (Reset),
        .flush_i    (flush),
        .in_valid_i (fetch_valid),
        .in_data_i  (bus.ImInstruction),
        .in_pc_i    (pc_q),
        .in_ready_o (slot_ready),
        .out_ready_i(bus.InstrReady),
        .out_valid_o(bus.InstrValid),
        .out_data_o (bus.InstrOut),
        .out_pc_o   (bus.InstrPc)
    );

endmodule
